// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the data-memory responder.
// Address map, power-on memory contents and the FSM state type live here.
package mem_pkg;

    localparam logic [31:0] DATA_BASE   = 32'h1001_0000;
    localparam logic [31:0] INIT_WORD0  = 32'd100;
    localparam logic [31:0] INIT_WORD1  = 32'd200;
    localparam int          LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Initial content of word i after clear.
    function automatic logic [31:0] init_word(input int i);
        if (i == 0)
            return INIT_WORD0;
        else if (i == 1)
            return INIT_WORD1;
        else
            return 32'd0;
    endfunction

endpackage

// File: rtl/word_ram.sv
// DEPTH_WORDS x 32 word store: asynchronous read, synchronous write,
// and clear-driven reload of the power-on contents.
module word_ram
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= init_word(i);
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for lw/sw requests: accepts one request, waits a
// fixed number of edges, then commits the access and pulses a response.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DATA_BASE,
    parameter int          DEPTH_WORDS = 64,
    parameter int          LATENCY     = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int AW = $clog2(DEPTH_WORDS);

    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be in 1..15");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("data_mem_responder: DEPTH_WORDS must be a power of two >= 2");
    end

    state_t        state;
    logic [3:0]    count;
    logic          cap_write;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;

    logic [31:0]   offset;
    logic          bad;
    logic          commit;
    logic          ram_we;
    logic [AW-1:0] index;
    logic [31:0]   ram_rdata;

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both 1; resp_valid is a one-cycle pulse with rdata/error.
    assign offset = cap_addr - BASE_ADDR;
    assign bad    = (cap_addr[1:0] != 2'b00) || (cap_addr < BASE_ADDR) ||
                    ((offset >> 2) >= 32'(DEPTH_WORDS));
    assign index  = offset[AW+1:2];
    assign commit = (state == WAIT) && (count == 4'd0);
    assign ram_we = commit && cap_write && !bad;

    word_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clock (clock),
        .clear (clear),
        .we    (ram_we),
        .addr  (index),
        .wdata (cap_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state      <= IDLE;
            count      <= 4'd0;
            cap_write  <= 1'b0;
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_write <= req_write;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        count     <= 4'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        // Commit edge: the read uses contents before this edge.
                        resp_valid <= 1'b1;
                        resp_error <= bad;
                        resp_rdata <= (bad || cap_write) ? 32'd0 : ram_rdata;
                        state      <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_error <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_error <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 instance and a LATENCY=1
// instance driven by directed steps, with responses checked from a queue.
module tb_data_mem_responder;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk;
    logic        clear      [2];
    logic        req_valid  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_error [2];

    int vectors;
    int miscompares;
    int cyc;
    int acc_cyc [2];
    int prev_acc;
    int hits;
    logic [32:0] exp_q[$];

    data_mem_responder #(.LATENCY(2)) u_dut0 (
        .clock      (clk),
        .clear      (clear[0]),
        .req_valid  (req_valid[0]),
        .req_write  (req_write[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .req_ready  (req_ready[0]),
        .resp_valid (resp_valid[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_error (resp_error[0])
    );

    data_mem_responder #(.LATENCY(1)) u_dut1 (
        .clock      (clk),
        .clear      (clear[1]),
        .req_valid  (req_valid[1]),
        .req_write  (req_write[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .req_ready  (req_ready[1]),
        .resp_valid (resp_valid[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_error (resp_error[1])
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request on instance d; expected response goes through the queue.
    task automatic do_req(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input logic hold, input string tag);
        int n;
        int lat;
        logic [32:0] e;
        lat = (d == 0) ? 2 : 1;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check({tag, ":ready_before"}, 64'(req_ready[d]), 64'd1);
        exp_q.push_back({exp_err, exp_rdata});
        acc_cyc[d]   = cyc;
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        step();
        check({tag, ":ready_after_accept"}, 64'(req_ready[d]), 64'd0);
        n = 1;
        while (resp_valid[d] !== 1'b1 && n < 40) begin
            req_addr[d]  = BASE + 32'($urandom_range(0, 63)) * 4;
            req_wdata[d] = $urandom;
            req_write[d] = 1'($urandom_range(0, 1));
            if (!hold)
                req_valid[d] = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        if (!hold)
            req_valid[d] = 1'b0;
        check({tag, ":latency"}, 64'(n), 64'(lat + 1));
        if (resp_valid[d] === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, ":rdata"}, 64'(resp_rdata[d]), 64'(e[31:0]));
            check({tag, ":error"}, 64'(resp_error[d]), 64'(e[32]));
            check({tag, ":ready_in_resp"}, 64'(req_ready[d]), 64'd0);
        end else begin
            check({tag, ":resp_seen"}, 64'(resp_valid[d]), 64'd1);
            exp_q.delete();
        end
        step();
        check({tag, ":resp_pulse_end"}, 64'(resp_valid[d]), 64'd0);
        check({tag, ":rdata_cleared"}, 64'(resp_rdata[d]), 64'd0);
        check({tag, ":error_cleared"}, 64'(resp_error[d]), 64'd0);
        check({tag, ":ready_back"}, 64'(req_ready[d]), 64'd1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            clear[d]     = 1'b1;
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
        end
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            check("reset:ready", 64'(req_ready[d]), 64'd1);
            check("reset:resp_valid", 64'(resp_valid[d]), 64'd0);
            check("reset:rdata", 64'(resp_rdata[d]), 64'd0);
            check("reset:error", 64'(resp_error[d]), 64'd0);
        end
        clear[0] = 1'b0;
        clear[1] = 1'b0;
        step();

        // Basic load and store/load with spacing
        do_req(0, 1'b0, BASE, 32'd0, 32'd100, 1'b0, 1'b0, "load_w0");
        do_req(0, 1'b1, BASE + 8, 32'd200, 32'd0, 1'b0, 1'b0, "store_w2");
        prev_acc = acc_cyc[0];
        do_req(0, 1'b0, BASE + 8, 32'd0, 32'd200, 1'b0, 1'b0, "load_w2");
        check("spacing_lat2", 64'(acc_cyc[0] - prev_acc), 64'd4);

        // Error cases, and erroring stores must not write anywhere
        do_req(0, 1'b0, BASE + 2, 32'd0, 32'd0, 1'b1, 1'b0, "misaligned");
        do_req(0, 1'b0, 32'h1000_FFFC, 32'd0, 32'd0, 1'b1, 1'b0, "below_base");
        do_req(0, 1'b0, BASE + 32'h100, 32'd0, 32'd0, 1'b1, 1'b0, "index64");
        do_req(0, 1'b1, BASE + 32'h100, 32'hAAAA5555, 32'd0, 1'b1, 1'b0, "store_index64");
        do_req(0, 1'b1, BASE + 6, 32'h5555AAAA, 32'd0, 1'b1, 1'b0, "store_misaligned");
        do_req(0, 1'b1, BASE - 4, 32'h0BAD0BAD, 32'd0, 1'b1, 1'b0, "store_below");
        do_req(0, 1'b0, BASE, 32'd0, 32'd100, 1'b0, 1'b0, "reload_w0");
        do_req(0, 1'b0, BASE + 4, 32'd0, 32'd200, 1'b0, 1'b0, "reload_w1");
        do_req(0, 1'b0, BASE + 252, 32'd0, 32'd0, 1'b0, 1'b0, "load_w63");

        // req_valid held high; responses follow the captured address
        do_req(0, 1'b1, BASE + 12, 32'h1234_5678, 32'd0, 1'b0, 1'b0, "store_w3");
        do_req(0, 1'b0, BASE + 12, 32'd0, 32'h1234_5678, 1'b0, 1'b1, "hold_w3");
        do_req(0, 1'b0, BASE, 32'd0, 32'd100, 1'b0, 1'b1, "hold_w0");
        do_req(0, 1'b0, BASE + 4, 32'd0, 32'd200, 1'b0, 1'b1, "hold_w1");
        req_valid[0] = 1'b0;
        step();

        // clear during WAIT of a store
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = BASE + 4;
        req_wdata[0] = 32'hDEAD_BEEF;
        step();
        req_valid[0] = 1'b0;
        check("clear:ready_after_accept", 64'(req_ready[0]), 64'd0);
        clear[0] = 1'b1;
        #1;
        check("clear:ready_async", 64'(req_ready[0]), 64'd1);
        step();
        clear[0] = 1'b0;
        check("clear:ready_immediate", 64'(req_ready[0]), 64'd1);
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid[0] === 1'b1)
                hits++;
            step();
        end
        check("clear:no_response", 64'(hits), 64'd0);
        do_req(0, 1'b0, BASE + 4, 32'd0, 32'd200, 1'b0, 1'b0, "clear:load_w1");
        do_req(0, 1'b0, BASE + 8, 32'd0, 32'd0, 1'b0, 1'b0, "clear:load_w2");
        do_req(0, 1'b0, BASE + 12, 32'd0, 32'd0, 1'b0, 1'b0, "clear:load_w3");

        // LATENCY=1 instance
        do_req(1, 1'b0, BASE, 32'd0, 32'd100, 1'b0, 1'b0, "lat1_load_w0");
        prev_acc = acc_cyc[1];
        do_req(1, 1'b0, BASE + 4, 32'd0, 32'd200, 1'b0, 1'b0, "lat1_load_w1");
        check("spacing_lat1", 64'(acc_cyc[1] - prev_acc), 64'd3);
        do_req(1, 1'b1, BASE + 16, 32'd7, 32'd0, 1'b0, 1'b0, "lat1_store_w4");
        do_req(1, 1'b0, BASE + 16, 32'd0, 32'd7, 1'b0, 1'b0, "lat1_load_w4");

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the datapath's lw/sw load/store interface; sits between the datapath and data storage.
- Stores a word array at the data-segment base 0x10010000 and answers each request after a programmable number of wait cycles.
- Handshake is valid/ready for requests and a single-cycle response pulse.
- Replaces the zero-latency data memory so multi-cycle datapath variants can be exercised against slow memory.

Parameters:
- BASE_ADDR, 32'h10010000, byte address of word 0.
- DEPTH_WORDS, 64, number of 32-bit words stored; power of two, at least 2.
- LATENCY, 2, edges from request acceptance to response; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_write  in  1  1 = sw (store), 0 = lw (load).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_error  out  1  qualified by resp_valid; request was misaligned or out of range.

Behaviour:
- Reset (clear=1, asynchronous):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, wait counter=0.
  - Memory word0=100, word1=200, all other words 0.
  - Latched request registers cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, capture req_write, req_addr and req_wdata, load counter=LATENCY-1, and go to WAIT.
  - With req_valid=0, stay in IDLE.
- WAIT:
  - req_ready=0.
  - If counter=0, go to RESP on the next edge; otherwise decrement the counter.
- Transition WAIT->RESP (commit edge):
  - Index = (addr-BASE_ADDR)>>2.
  - Error if addr[1:0]!=0 or addr<BASE_ADDR or index>=DEPTH_WORDS.
  - Store without error: write word[index]=wdata; resp_rdata=0.
  - Load without error: resp_rdata=word[index], using the memory contents before this edge.
  - Error: no memory write, resp_rdata=0, resp_error=1.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - Next edge returns to IDLE, with resp_valid, resp_rdata and resp_error cleared.
- Timing:
  - A request accepted at edge k gives resp_valid high during the cycle after edge k+LATENCY.
  - Minimum request spacing is LATENCY+2 cycles.
- Request inputs are ignored while req_ready=0; the captured copy is used, so the requester may change them freely.
- Subtraction uses 32-bit unsigned arithmetic; the index is taken from the low log2(DEPTH_WORDS) bits after the range check.
- clear mid-operation:
  - The pending request is dropped and no response is produced.
  - A store not yet at its commit edge never writes.
  - Memory reinitialises to reset contents.
- Illegal LATENCY (0 or >15) is rejected by a static elaboration check.

Decomposition:
- Shared package mem_pkg: DATA_BASE=32'h10010000, INIT_WORD0=100, INIT_WORD1=200, state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), and LATENCY_MAX=15.
- One sub-module, word_ram:
  - DEPTH_WORDS x 32 storage with asynchronous read.
  - Synchronous write enable.
  - Clear-driven reinitialisation to package init values.
- The FSM, counter, address check and response registers stay in data_mem_responder.

Test Plan:
- Reset then load at 0x10010000, LATENCY=2 -> req_ready drops after the accept edge; resp_valid high in the cycle after accept+2 edges; resp_rdata=100; resp_error=0.
- Store 200 to 0x10010008, then load 0x10010008 -> first response rdata=0 with error=0; second response rdata=200; next request accepted no sooner than 4 cycles after the previous accept.
- Load at 0x10010002 (misaligned), 0x1000FFFC (below base) and 0x10010100 (index 64, out of range) -> each gives resp_error=1, resp_rdata=0, and memory unchanged (reload of 0x10010004 returns 200).
- req_valid held high continuously with changing addresses -> exactly one accept per IDLE visit; response data matches the captured address, not the current req_addr.
- Store of 0xDEADBEEF to 0x10010004 with clear pulsed during WAIT -> no resp_valid; after clear, load of 0x10010004 returns 200 and req_ready=1 immediately.
- LATENCY=1 build: load of 0x10010000 accepted at edge k -> resp_valid in the cycle after edge k+1; back-to-back request spacing is 3 cycles.
